// File: rtl/rect_frame_sched_pkg.sv
// Shared definitions for the rect frame scheduler.
// Holds the default geometry (rects per class, coordinate and possibility
// widths) and the field layout of one rect entry {x1,y1,x2,y2}, x1 in the MSBs.
package rect_frame_sched_pkg;

  localparam int DEF_RECT_NUMMAX        = 8;
  localparam int POSITION_WIDTH         = 8;
  localparam int RECT_POSSIBILITY_WIDTH = 8;

  // Field indices inside one entry, counted from the LSB end.
  localparam int FLD_Y2 = 0;
  localparam int FLD_X2 = 1;
  localparam int FLD_Y1 = 2;
  localparam int FLD_X1 = 3;

  // LSB position of a field for a given coordinate width.
  function automatic int fld_lsb(input int fld, input int pw);
    return fld * pw;
  endfunction

endpackage

// File: rtl/rect_frame_sched_if.sv
// Bundle between the detector streams / vsync source and the scheduler,
// and between the scheduler and the overlay stage.
//   master : detector + overlay side (drives i_*, observes o_*)
//   slave  : the scheduler (observes i_*, drives o_*)
interface rect_frame_sched_if #(
  parameter int RECT_NUMMAX = 8,
  parameter int P_W         = 8,
  parameter int R_W         = 8
);
  localparam int CNT_W  = $clog2(RECT_NUMMAX + 1);
  localparam int RECT_W = 4 * P_W;

  logic                      i_vs;
  logic                      i_head_valid;
  logic                      o_head_ready;
  logic [RECT_W-1:0]         i_head_rect;
  logic [R_W-1:0]            i_head_posi;
  logic                      i_hair_valid;
  logic                      o_hair_ready;
  logic [RECT_W-1:0]         i_hair_rect;
  logic                      o_start;
  logic [RECT_NUMMAX*RECT_W-1:0] o_head_wire;
  logic [RECT_NUMMAX*RECT_W-1:0] o_hair_wire;
  logic [RECT_NUMMAX*R_W-1:0]    o_posi_wire;
  logic [CNT_W-1:0]          o_head_num;
  logic [CNT_W-1:0]          o_hair_num;
  logic                      o_ovf;

  modport master (
    output i_vs, i_head_valid, i_head_rect, i_head_posi, i_hair_valid, i_hair_rect,
    input  o_head_ready, o_hair_ready, o_start, o_head_wire, o_hair_wire,
           o_posi_wire, o_head_num, o_hair_num, o_ovf
  );

  modport slave (
    input  i_vs, i_head_valid, i_head_rect, i_head_posi, i_hair_valid, i_hair_rect,
    output o_head_ready, o_hair_ready, o_start, o_head_wire, o_hair_wire,
           o_posi_wire, o_head_num, o_hair_num, o_ovf
  );

endinterface

// File: rtl/rect_frame_sched_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst     : clock, synchronous active-high reset
//   en           : arbitration enabled (grants forced low otherwise)
//   req_a, req_b : requests (a = head stream, b = hair stream)
//   gnt_a, gnt_b : combinational grants, at most one high
// The pointer only moves after a contended grant, so a lone requester
// never steals the other stream's turn.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_r;      // 0: a wins the next contention, 1: b wins
  logic both_s;

  // Grant decode from requests and pointer.
  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    both_s = req_a & req_b;
    if (en) begin
      if (both_s) begin
        gnt_a = ~ptr_r;
        gnt_b = ptr_r;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Pointer toggles after each contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (en && both_s) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/rect_frame_sched.sv
// Frame-synchronous rect scheduler feeding the overlay stage.
// Collects head/hair rect entries into a shadow file during a frame; on a
// vsync rising edge it publishes the whole file atomically (one PUBLISH
// cycle), then strobes o_start for one cycle.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : detector handshakes, vsync, published rect wires,
//                      counts, overflow flag, start strobe
module rect_frame_sched
  import rect_frame_sched_pkg::*;
#(
  parameter int RECT_NUMMAX = DEF_RECT_NUMMAX,
  parameter int P_W         = POSITION_WIDTH,
  parameter int R_W         = RECT_POSSIBILITY_WIDTH
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  rect_frame_sched_if.slave bus
);

  localparam int CNT_W  = $clog2(RECT_NUMMAX + 1);
  localparam int IDX_W  = (RECT_NUMMAX > 1) ? $clog2(RECT_NUMMAX) : 1;
  localparam int RECT_W = 4 * P_W;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PUBLISH = 2'd1;
  localparam logic [1:0] ST_START   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RECT_NUMMAX);

  // An entry with inverted corners cannot be drawn; it is dropped.
  function automatic logic rect_malformed(input logic [RECT_W-1:0] r);
    logic [P_W-1:0] x1, y1, x2, y2;
    x1 = r[fld_lsb(FLD_X1, P_W) +: P_W];
    y1 = r[fld_lsb(FLD_Y1, P_W) +: P_W];
    x2 = r[fld_lsb(FLD_X2, P_W) +: P_W];
    y2 = r[fld_lsb(FLD_Y2, P_W) +: P_W];
    return (x1 > x2) || (y1 > y2);
  endfunction

  logic [1:0]        state_r;
  logic              vs_d_r;
  logic              vs_edge_s;
  logic              collect_s;
  logic              gnt_head_s;
  logic              gnt_hair_s;
  logic              head_acc_s;
  logic              hair_acc_s;
  logic              head_drop_s;
  logic              hair_drop_s;

  logic [RECT_W-1:0] head_rect_r [RECT_NUMMAX];
  logic [R_W-1:0]    head_posi_r [RECT_NUMMAX];
  logic [RECT_W-1:0] hair_rect_r [RECT_NUMMAX];
  logic [CNT_W-1:0]  head_cnt_r;
  logic [CNT_W-1:0]  hair_cnt_r;
  logic              ovf_sticky_r;

  logic                          o_start_r;
  logic [RECT_NUMMAX*RECT_W-1:0] o_head_wire_r;
  logic [RECT_NUMMAX*RECT_W-1:0] o_hair_wire_r;
  logic [RECT_NUMMAX*R_W-1:0]    o_posi_wire_r;
  logic [CNT_W-1:0]              o_head_num_r;
  logic [CNT_W-1:0]              o_hair_num_r;
  logic                          o_ovf_r;

  rr_arb2 u_arb (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .en    (collect_s),
    .req_a (bus.i_head_valid),
    .req_b (bus.i_hair_valid),
    .gnt_a (gnt_head_s),
    .gnt_b (gnt_hair_s)
  );

  // Handshake and drop decode for the current cycle.
  always_comb begin
    collect_s   = (state_r == ST_COLLECT);
    vs_edge_s   = bus.i_vs & ~vs_d_r;
    head_acc_s  = bus.i_head_valid & gnt_head_s;
    hair_acc_s  = bus.i_hair_valid & gnt_hair_s;
    head_drop_s = rect_malformed(bus.i_head_rect) || (head_cnt_r == CNT_FULL);
    hair_drop_s = rect_malformed(bus.i_hair_rect) || (hair_cnt_r == CNT_FULL);
  end

  // Frame FSM, vsync edge register and shadow rect file.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_COLLECT;
      vs_d_r       <= 1'b0;
      head_cnt_r   <= '0;
      hair_cnt_r   <= '0;
      ovf_sticky_r <= 1'b0;
      o_start_r    <= 1'b0;
      for (int k = 0; k < RECT_NUMMAX; k++) begin
        head_rect_r[k] <= '0;
        head_posi_r[k] <= '0;
        hair_rect_r[k] <= '0;
      end
    end else begin
      vs_d_r    <= bus.i_vs;
      o_start_r <= 1'b0;
      case (state_r)
        ST_COLLECT: begin
          if (vs_edge_s) begin
            state_r <= ST_PUBLISH;
          end else begin
            state_r <= ST_COLLECT;
          end
          if (head_acc_s) begin
            if (head_drop_s) begin
              ovf_sticky_r <= 1'b1;
            end else begin
              head_rect_r[head_cnt_r[IDX_W-1:0]] <= bus.i_head_rect;
              head_posi_r[head_cnt_r[IDX_W-1:0]] <= bus.i_head_posi;
              head_cnt_r <= head_cnt_r + CNT_W'(1);
            end
          end
          if (hair_acc_s) begin
            if (hair_drop_s) begin
              ovf_sticky_r <= 1'b1;
            end else begin
              hair_rect_r[hair_cnt_r[IDX_W-1:0]] <= bus.i_hair_rect;
              hair_cnt_r <= hair_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_PUBLISH: begin
          // The publish registers sample the counts this cycle, so the
          // clear lands after they have been copied.
          head_cnt_r   <= '0;
          hair_cnt_r   <= '0;
          ovf_sticky_r <= 1'b0;
          o_start_r    <= 1'b1;
          state_r      <= ST_START;
        end
        ST_START: begin
          state_r <= ST_COLLECT;
        end
        default: begin
          state_r <= ST_COLLECT;
        end
      endcase
    end
  end

  // Publish registers: loaded only in PUBLISH, held otherwise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      o_head_wire_r <= '0;
      o_hair_wire_r <= '0;
      o_posi_wire_r <= '0;
      o_head_num_r  <= '0;
      o_hair_num_r  <= '0;
      o_ovf_r       <= 1'b0;
    end else if (state_r == ST_PUBLISH) begin
      // Slots at or beyond the count may hold stale entries from an
      // earlier frame; they publish as zero rects.
      for (int k = 0; k < RECT_NUMMAX; k++) begin
        if (CNT_W'(k) < head_cnt_r) begin
          o_head_wire_r[k*RECT_W +: RECT_W] <= head_rect_r[k];
          o_posi_wire_r[k*R_W +: R_W]       <= head_posi_r[k];
        end else begin
          o_head_wire_r[k*RECT_W +: RECT_W] <= '0;
          o_posi_wire_r[k*R_W +: R_W]       <= '0;
        end
        if (CNT_W'(k) < hair_cnt_r) begin
          o_hair_wire_r[k*RECT_W +: RECT_W] <= hair_rect_r[k];
        end else begin
          o_hair_wire_r[k*RECT_W +: RECT_W] <= '0;
        end
      end
      o_head_num_r <= head_cnt_r;
      o_hair_num_r <= hair_cnt_r;
      o_ovf_r      <= ovf_sticky_r;
    end else begin
      o_head_wire_r <= o_head_wire_r;
      o_hair_wire_r <= o_hair_wire_r;
      o_posi_wire_r <= o_posi_wire_r;
      o_head_num_r  <= o_head_num_r;
      o_hair_num_r  <= o_hair_num_r;
      o_ovf_r       <= o_ovf_r;
    end
  end

  assign bus.o_head_ready = gnt_head_s;
  assign bus.o_hair_ready = gnt_hair_s;
  assign bus.o_start      = o_start_r;
  assign bus.o_head_wire  = o_head_wire_r;
  assign bus.o_hair_wire  = o_hair_wire_r;
  assign bus.o_posi_wire  = o_posi_wire_r;
  assign bus.o_head_num   = o_head_num_r;
  assign bus.o_hair_num   = o_hair_num_r;
  assign bus.o_ovf        = o_ovf_r;

endmodule

// File: tb/tb_rect_frame_sched.sv
// Self-checking bench for rect_frame_sched: directed scenarios followed by
// randomized frames, compared against a queue-based frame model.
module tb_rect_frame_sched;

  localparam int NMAX = 8;
  localparam int PW   = 8;
  localparam int RW   = 8;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int CKW  = NMAX * 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  rect_frame_sched_if #(.RECT_NUMMAX(NMAX), .P_W(PW), .R_W(RW)) bus ();

  rect_frame_sched #(.RECT_NUMMAX(NMAX), .P_W(PW), .R_W(RW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (frame level) ----------------
  int          m_phase;       // 0 collecting, 1 publishing, 2 start strobe
  bit          m_vs_prev;
  bit          m_pref_hair;   // who wins the next contention
  logic [31:0] m_head_q[$];
  logic [7:0]  m_posi_q[$];
  logic [31:0] m_hair_q[$];
  bit          m_ovf;
  logic [CKW-1:0]     exp_head_wire, exp_hair_wire;
  logic [NMAX*RW-1:0] exp_posi_wire;
  logic [CW-1:0]      exp_head_num, exp_hair_num;
  bit                 exp_ovf;

  task automatic check(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] r);
    return (r[31:24] > r[15:8]) || (r[23:16] > r[7:0]);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_vs_prev = 1'b0; m_pref_hair = 1'b0; m_ovf = 1'b0;
    m_head_q.delete(); m_posi_q.delete(); m_hair_q.delete();
    exp_head_wire = '0; exp_hair_wire = '0; exp_posi_wire = '0;
    exp_head_num = '0; exp_hair_num = '0; exp_ovf = 1'b0;
  endtask

  task automatic model_publish();
    exp_head_wire = '0; exp_hair_wire = '0; exp_posi_wire = '0;
    foreach (m_head_q[k]) begin
      exp_head_wire[32*k +: 32] = m_head_q[k];
      exp_posi_wire[RW*k +: RW] = m_posi_q[k];
    end
    foreach (m_hair_q[k]) exp_hair_wire[32*k +: 32] = m_hair_q[k];
    exp_head_num = CW'(m_head_q.size());
    exp_hair_num = CW'(m_hair_q.size());
    exp_ovf = m_ovf;
    m_head_q.delete(); m_posi_q.delete(); m_hair_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock cycle: drive, check, then advance the model past the edge.
  task automatic cycle(input bit rst, input bit vs,
                       input bit hv, input logic [31:0] hr, input logic [7:0] hp,
                       input bit av, input logic [31:0] ar);
    bit er_head, er_hair, edge_seen;
    @(negedge sys_clk);
    sys_rst          = rst;
    bus.i_vs         = vs;
    bus.i_head_valid = hv;
    bus.i_head_rect  = hr;
    bus.i_head_posi  = hp;
    bus.i_hair_valid = av;
    bus.i_hair_rect  = ar;
    #1;
    er_head = 1'b0; er_hair = 1'b0;
    if (m_phase == 0) begin
      if (hv && av) begin
        er_head = !m_pref_hair; er_hair = m_pref_hair;
      end else begin
        er_head = hv; er_hair = av;
      end
    end
    if (!rst) begin
      check("head_ready", CKW'(bus.o_head_ready), CKW'(er_head));
      check("hair_ready", CKW'(bus.o_hair_ready), CKW'(er_hair));
    end
    check("start",     CKW'(bus.o_start), CKW'(m_phase == 2));
    check("head_wire", bus.o_head_wire, exp_head_wire);
    check("hair_wire", bus.o_hair_wire, exp_hair_wire);
    check("posi_wire", CKW'(bus.o_posi_wire), CKW'(exp_posi_wire));
    check("nums_ovf",  CKW'({bus.o_head_num, bus.o_hair_num, bus.o_ovf}),
                       CKW'({exp_head_num, exp_hair_num, exp_ovf}));
    if (rst) begin
      model_reset();
    end else begin
      edge_seen = vs && !m_vs_prev;
      m_vs_prev = vs;
      case (m_phase)
        0: begin
          if (hv && av) m_pref_hair = !m_pref_hair;
          if (er_head) begin
            if (is_bad(hr) || m_head_q.size() == NMAX) m_ovf = 1'b1;
            else begin m_head_q.push_back(hr); m_posi_q.push_back(hp); end
          end
          if (er_hair) begin
            if (is_bad(ar) || m_hair_q.size() == NMAX) m_ovf = 1'b1;
            else m_hair_q.push_back(ar);
          end
          if (edge_seen) m_phase = 1;
        end
        1: begin model_publish(); m_phase = 2; end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
  endtask

  task automatic frame_edge();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    idle(4);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    idle(1);
  endtask

  function automatic logic [31:0] rnd_rect();
    logic [7:0] x1, y1, x2, y2;
    x1 = 8'($urandom_range(0, 200));
    y1 = 8'($urandom_range(0, 200));
    x2 = x1 + 8'($urandom_range(0, 55));
    y2 = y1 + 8'($urandom_range(0, 55));
    if ($urandom_range(0, 7) == 0) begin
      x1 = 8'd250; x2 = 8'd3;
    end
    return {x1, y1, x2, y2};
  endfunction

  initial begin
    bus.i_vs = 1'b0; bus.i_head_valid = 1'b0; bus.i_head_rect = '0;
    bus.i_head_posi = '0; bus.i_hair_valid = 1'b0; bus.i_hair_rect = '0;
    model_reset();
    do_reset();

    // Empty frame: start strobe two cycles after the edge, all zero.
    frame_edge();

    // Three head entries.
    cycle(1'b0, 1'b0, 1'b1, {8'd10, 8'd20, 8'd30, 8'd40}, 8'h11, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, {8'd1, 8'd1, 8'd2, 8'd2},     8'h22, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, {8'd5, 8'd5, 8'd9, 8'd9},     8'h33, 1'b0, 32'h0);
    frame_edge();
    check("dir_head_num", CKW'(bus.o_head_num), CKW'(4'd3));
    check("dir_slot0", CKW'(bus.o_head_wire[31:0]), CKW'(32'h0A141E28));
    check("dir_posi", CKW'(bus.o_posi_wire[23:0]), CKW'(24'h332211));
    check("dir_slots_hi", CKW'(bus.o_head_wire[CKW-1:96]), CKW'(160'h0));

    // Contention from reset: head, hair, head, hair.
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b1, {8'd1, 8'd1, 8'd10, 8'(10 + i)}, 8'(i),
            1'b1, {8'd2, 8'd2, 8'd20, 8'(20 + i)});
    frame_edge();
    check("rr_nums", CKW'({bus.o_head_num, bus.o_hair_num}), CKW'({4'd2, 4'd2}));
    check("rr_head", CKW'(bus.o_head_wire[63:0]), CKW'({8'd1, 8'd1, 8'd10, 8'd12, 8'd1, 8'd1, 8'd10, 8'd10}));
    check("rr_hair", CKW'(bus.o_hair_wire[63:0]), CKW'({8'd2, 8'd2, 8'd20, 8'd23, 8'd2, 8'd2, 8'd20, 8'd21}));

    // Hair overflow: 10 sent, 8 kept.
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, {8'(i), 8'd0, 8'd100, 8'd100});
    frame_edge();
    check("ovf_num", CKW'(bus.o_hair_num), CKW'(4'd8));
    check("ovf_flag", CKW'(bus.o_ovf), CKW'(1'b1));
    frame_edge();
    check("ovf_clear", CKW'(bus.o_ovf), CKW'(1'b0));

    // Malformed head entry.
    cycle(1'b0, 1'b0, 1'b1, {8'd30, 8'd0, 8'd10, 8'd0}, 8'h44, 1'b0, 32'h0);
    frame_edge();
    check("bad_num", CKW'(bus.o_head_num), CKW'(4'd0));
    check("bad_ovf", CKW'(bus.o_ovf), CKW'(1'b1));

    // Valid held across the edge: accepted only once COLLECT resumes.
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, {8'd7, 8'd8, 8'd9, 8'd10}, 8'h55, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, {8'd7, 8'd8, 8'd9, 8'd10}, 8'h55, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, {8'd7, 8'd8, 8'd9, 8'd10}, 8'h55, 1'b0, 32'h0);
    idle(3);
    frame_edge();
    check("hold_num", CKW'(bus.o_head_num), CKW'(4'd1));
    check("hold_slot0", CKW'(bus.o_head_wire[31:0]), CKW'(32'h0708090A));

    // Reset while publishing: nothing of the partial frame appears.
    cycle(1'b0, 1'b0, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4}, 8'h66, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
    idle(4);
    check("rst_pub", CKW'({bus.o_head_num, bus.o_start}), CKW'(5'd0));

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(4, 20);
      for (int c = 0; c < len; c++)
        cycle(1'b0, (c == 0), ($urandom_range(0, 1) == 1), rnd_rect(), 8'($urandom),
              ($urandom_range(0, 1) == 1), rnd_rect());
    end
    frame_edge();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rect_frame_sched.md
Name: rect_frame_sched

Overview:
- Frame-synchronous scheduler that feeds the rectangle/ASCII overlay stage.
- Collects head-rect and hair-rect entries from two detector streams through a shared single-write-port shadow buffer, using round-robin arbitration.
- On each frame start, atomically publishes the buffer as packed rect wires plus the per-rect possibility wire, then pulses the overlay start strobe.
- Sits between the detection post-processing and the overlay block; the overlay therefore never sees a half-updated rect list.

Parameters:
- RECT_NUMMAX, 8, max rects per class per frame (`RECT_NUMMAX).
- P_W, 8, coordinate width; one entry = {x1,y1,x2,y2} = 4*P_W = 32 bits.
- R_W, 8, possibility field width per head rect.
- CNT_W (localparam), $clog2(RECT_NUMMAX+1), count width.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- i_vs  in  1  video vsync; a rising edge marks frame start.
- i_head_valid  in  1  head entry valid.
- o_head_ready  out  1  head entry accepted when valid&ready.
- i_head_rect  in  4*P_W  {x1,y1,x2,y2}, x1 in MSBs.
- i_head_posi  in  R_W  possibility of the head entry.
- i_hair_valid  in  1  hair entry valid.
- o_hair_ready  out  1  hair entry accepted when valid&ready.
- i_hair_rect  in  4*P_W  {x1,y1,x2,y2}.
- o_start  out  1  one-cycle strobe after publish.
- o_head_wire  out  RECT_NUMMAX*32  published head rects; slot k at bits [32k+31:32k].
- o_hair_wire  out  RECT_NUMMAX*32  published hair rects.
- o_posi_wire  out  RECT_NUMMAX*8  published possibilities; slot k at [8k+7:8k].
- o_head_num  out  CNT_W  published head count.
- o_hair_num  out  CNT_W  published hair count.
- o_ovf  out  1  previous frame dropped ≥1 entry (overflow or malformed).

Behaviour:
- Reset: every output 0; state COLLECT; shadow counts 0; round-robin pointer set to head; vs edge register 0.
- vs edge: vs_d registered each cycle; edge = i_vs & ~vs_d.
- FSM states:
  - COLLECT: ready outputs follow the arbiter. An edge moves to PUBLISH.
  - PUBLISH, 1 cycle: both ready outputs low.
    - Copy shadow slots 0..count-1 to the outputs. Slots ≥ count publish as all-zero (zero rect = invalid).
    - Latch counts and the sticky overflow flag into o_head_num, o_hair_num, o_ovf.
    - Clear shadow counts and the sticky flag.
    - Next state START.
  - START, 1 cycle: o_start=1, readies low; next state COLLECT.
- Edges seen in PUBLISH or START are ignored. The environment guarantees ≥3 cycles between vs rising edges.
- Arbiter (COLLECT only), one write per cycle:
  - Only one valid: that stream gets ready=1.
  - Both valid: the stream named by the pointer gets ready; the other gets ready=0. The pointer toggles only after a grant made while both were valid.
  - Readies are combinational from valid and state; valid must not depend on ready.
- Accept path (valid&ready):
  - Entry is malformed if x1>x2 or y1>y2 (unsigned compare). Malformed entries are consumed, not stored, and set the sticky flag.
  - If the class count equals RECT_NUMMAX, the entry is consumed, not stored, and sets the sticky flag. The count saturates.
  - Otherwise store at slot[count] (head also stores posi) and increment count.
- Latency:
  - vs edge registered at cycle N → PUBLISH at N+1 → published outputs valid at N+2, same cycle o_start=1.
  - Outputs hold until the next publish.
- Shadow state persists across frames only until publish; no carry-over of entries.
- Reset mid-frame or mid-PUBLISH: immediate return to reset values; a partial publish is never visible.

Decomposition:
- Shared package `define.v` holds RECT_NUMMAX, POSITION_WIDTH, RECT_POSSIBILITY_WIDTH, and the rect entry field offsets (X1/Y1/X2/Y2 bit positions).
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with pointer register and grant outputs.
- Shadow file, FSM and publish registers stay in the top module.

Test Plan:
- Reset then vs edge with no entries → o_start pulse at edge+2; all wires 0; nums 0; o_ovf 0.
- 3 head entries {10,20,30,40}, {1,1,2,2}, {5,5,9,9} with posi 0x11,0x22,0x33, then edge → o_head_num=3; slot0=0x0A141E28; o_posi_wire[23:0]=0x332211; slots 3..7 zero.
- Head and hair both valid for 4 consecutive cycles → grants alternate head, hair, head, hair; 2 entries each stored in order.
- 10 hair entries in one frame → 8 stored, 2 dropped; o_hair_num=8; o_ovf=1 after publish; next empty frame gives o_ovf=0.
- Head entry {30,0,10,0} (x1>x2) → consumed with ready=1, not stored; o_ovf=1.
- vs edge while valid held high → readies low in PUBLISH and START; held entry accepted in the following COLLECT cycle into the new frame's slot0.
